day1_line_parser: RTL
=====================

# day1_line_parser

Streaming ASCII front end for the day-1 dial solver. Consumes puzzle-input bytes (lines such as "L68\n", "R48\n") over a valid/ready byte interface. Converts each line to a signed rotation record: negative for L, positive for R. Drives the solver's valid/dir/n input, so the solver can be fed directly from a file or UART byte stream instead of a bench task.

## Interface
- N_W, 32: width of the signed rotation output.
- MAX_DIGITS, 9: maximum decimal digits per line; more is a format error.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- in_valid  in  1  byte on in_data is valid.
- in_data  in  8  ASCII byte.
- in_last  in  1  qualifies the current byte as the final byte of the file.
- in_ready  out  1  parser accepts a byte this cycle.
- out_valid  out  1  rotation record valid; held until out_ready.
- out_ready  in  1  consumer accepts record; tie high for the solver, which has no backpressure.
- out_dir  out  1  1 = R, 0 = L.
- out_n  out  N_W  signed rotation: +mag for R, -mag for L.
- done  out  1  sticky; end of file reached cleanly.
- err  out  1  sticky; illegal format seen.
- rec_count  out  32  records emitted (see Configuration).

## Operation
- States: IDLE, DIGITS, EMIT, DONE, ERR. Byte accepted when in_valid && in_ready.
- IDLE:
  - 'L' or 'R': latch dir, clear mag and digit count, go to DIGITS.
  - '\n' and '\r': skipped, so blank lines are legal.
  - Any other byte: ERR.
- DIGITS:
  - '0'..'9': mag = mag*10 + (byte-0x30); digit count +1.
  - '\n' or '\r' with digit count ≥ 1: go to EMIT.
  - Terminator with zero digits, any other byte, or digit count exceeding MAX_DIGITS: ERR.
- EMIT:
  - out_valid=1; out_n = dir ? mag : -mag; out_dir = dir.
  - On out_ready: go to IDLE, or to DONE if the line's terminator carried in_last.
- in_last rules:
  - in_last on a digit in DIGITS: that digit is the terminator; record emitted, then DONE.
  - in_last on a terminator/blank in IDLE: DONE.
  - in_last on 'L'/'R': ERR.
- DONE and ERR are absorbing until reset. In both, in_ready=0 and out_valid=0.
- mag is unsigned N_W-1 bits. MAX_DIGITS must fit; the default 9 digits fits 31 bits.

## Timing
- Reset values:
  - state IDLE; out_valid 0, out_dir 0, out_n 0.
  - done 0, err 0, rec_count 0.
  - in_ready 1: it is combinational, 1 in IDLE/DIGITS, 0 otherwise.
- Latency: terminator accepted in cycle k, so out_valid is high in cycle k+1 (registered).
- Throughput: one byte/cycle, plus one bubble per record (EMIT) when out_ready is high.
- out_n and out_dir stay stable while out_valid && !out_ready.
- out_valid is a single-cycle pulse per record when out_ready is tied high. This matches the solver's valid sampling.
- Reset assertion mid-line or mid-EMIT: immediate return to reset values. The partial record is discarded.

## Configuration
- DAY1_PARSER_STATS_EN:
  - Defined: rec_count increments on each out_valid && out_ready and saturates at 2^32-1.
  - Undefined: rec_count is constant 0 and the counter is not synthesized.

## Structure
- Package day1_pkg holds:
  - ASCII constants: CH_L=0x4C, CH_R=0x52, CH_LF=0x0A, CH_CR=0x0D, CH_0=0x30, CH_9=0x39.
  - Parser state enum typedef.
  - Default N_W.
- One sub-module, day1_digit_acc:
  - Holds the mag register and digit counter.
  - clear/step inputs; outputs mag and overflow (digit count > MAX_DIGITS).
- Parser FSM instantiates it once.

## Test plan
- Bytes "L68\nR48\n", out_ready=1:
  - Record 1: out_valid one cycle after the first '\n', out_n=-68, out_dir=0.
  - Record 2: out_n=+48, out_dir=1.
  - rec_count=2 with DAY1_PARSER_STATS_EN.
- Full 10-line sample (L68 L30 R48 L5 R60 L55 L1 L99 R14 L82), fed into the solver:
  - Solver ends with xOut=32 and zeroCount=3.
  - Parser done=1, err=0.
- Backpressure, "R5\n" with out_ready low for 3 cycles:
  - out_valid held 4 cycles with out_n=+5.
  - in_ready=0 throughout.
  - Next byte accepted only after the handshake.
- Malformed inputs, each raising err in the cycle after the bad byte, with no out_valid:
  - "X12\n": bad leading byte.
  - "L\n": no digits.
  - "R1234567890\n": 10 digits exceeds MAX_DIGITS=9.
- "R7" with in_last on '7':
  - Record +7 emitted, then done=1.
  - Blank line "\r\n\n" before it produces no records.
- rst asserted mid-line after "L12":
  - Outputs return to reset values asynchronously.
  - Subsequent "R3\n" yields out_n=+3.

Source files
------------

// File: rtl/day1_pkg.sv
// Shared constants and state encoding for the day-1 ASCII line parser.
package day1_pkg;

  localparam int N_W_DEFAULT        = 32;
  localparam int MAX_DIGITS_DEFAULT = 9;

  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DIGITS = 3'd1,
    ST_EMIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } parser_state_e;

endpackage

// File: rtl/day1_digit_acc.sv
// Decimal magnitude accumulator: mag = mag*10 + digit, with a digit counter.
// overflow flags a step that would push the digit count past MAX_DIGITS.
module day1_digit_acc
  import day1_pkg::*;
#(
  parameter int N_W        = N_W_DEFAULT,
  parameter int MAX_DIGITS = MAX_DIGITS_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           step,
  input  logic [3:0]     digit,
  output logic [N_W-2:0] mag,
  output logic           has_digits,
  output logic           overflow
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  logic [CNT_W-1:0] count;
  logic [N_W-2:0]   mag_x10;
  logic [N_W-2:0]   mag_next;

  // x10 as x8 + x2; MAX_DIGITS is chosen so this never wraps
  assign mag_x10    = (mag << 3) + (mag << 1);
  assign mag_next   = mag_x10 + (N_W-1)'(digit);
  assign overflow   = step && (count == CNT_W'(MAX_DIGITS));
  assign has_digits = (count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mag   <= '0;
      count <= '0;
    end else if (clear) begin
      mag   <= '0;
      count <= '0;
    end else if (step && !overflow) begin
      mag   <= mag_next;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/day1_line_parser.sv
// Streaming byte parser turning L/R rotation text lines into signed rotation records.
// Optional saturating record counter enabled by DAY1_PARSER_STATS_EN.
module day1_line_parser
  import day1_pkg::*;
#(
  parameter int N_W        = N_W_DEFAULT,
  parameter int MAX_DIGITS = MAX_DIGITS_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [7:0]     in_data,
  input  logic           in_last,
  output logic           in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_dir,
  output logic [N_W-1:0] out_n,
  output logic           done,
  output logic           err,
  output logic [31:0]    rec_count,
  output parser_state_e  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the source holds its payload stable while valid && !ready.

  parser_state_e  state, state_n;
  logic           accept, is_digit, is_term, is_dir;
  logic           acc_clear, acc_step, acc_ovf, acc_any;
  logic [N_W-2:0] mag;
  logic [N_W-1:0] mag_ext;
  logic           dir_q, dir_load;
  logic           last_q, last_load;

  assign in_ready  = (state == ST_IDLE) || (state == ST_DIGITS);
  assign accept    = in_valid && in_ready;
  assign is_digit  = (in_data >= CH_0) && (in_data <= CH_9);
  assign is_term   = (in_data == CH_LF) || (in_data == CH_CR);
  assign is_dir    = (in_data == CH_L) || (in_data == CH_R);

  assign out_valid = (state == ST_EMIT);
  assign done      = (state == ST_DONE);
  assign err       = (state == ST_ERR);
  assign dbg_state = state;
  assign out_dir   = dir_q;
  assign mag_ext   = {1'b0, mag};
  assign out_n     = dir_q ? mag_ext : -mag_ext;

  day1_digit_acc #(
    .N_W        (N_W),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .clear      (acc_clear),
    .step       (acc_step),
    .digit      (in_data[3:0]),
    .mag        (mag),
    .has_digits (acc_any),
    .overflow   (acc_ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      dir_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      state <= state_n;
      if (dir_load)  dir_q  <= (in_data == CH_R);
      if (last_load) last_q <= in_last;
    end
  end

  always_comb begin
    state_n   = state;
    acc_clear = 1'b0;
    acc_step  = 1'b0;
    dir_load  = 1'b0;
    last_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (is_dir) begin
            if (in_last) begin
              state_n = ST_ERR;
            end else begin
              dir_load  = 1'b1;
              acc_clear = 1'b1;
              state_n   = ST_DIGITS;
            end
          end else if (is_term) begin
            if (in_last) state_n = ST_DONE;
          end else begin
            state_n = ST_ERR;
          end
        end
      end
      ST_DIGITS: begin
        if (accept) begin
          if (is_digit) begin
            acc_step = 1'b1;
            // a digit carrying in_last doubles as the line terminator
            if (acc_ovf) begin
              state_n = ST_ERR;
            end else if (in_last) begin
              last_load = 1'b1;
              state_n   = ST_EMIT;
            end
          end else if (is_term && acc_any) begin
            last_load = 1'b1;
            state_n   = ST_EMIT;
          end else begin
            state_n = ST_ERR;
          end
        end
      end
      ST_EMIT: begin
        if (out_ready) state_n = last_q ? ST_DONE : ST_IDLE;
      end
      ST_DONE: state_n = ST_DONE;
      ST_ERR:  state_n = ST_ERR;
      default: state_n = ST_ERR;
    endcase
  end

`ifdef DAY1_PARSER_STATS_EN
  logic [31:0] rec_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rec_count_q <= '0;
    end else if (out_valid && out_ready && (rec_count_q != '1)) begin
      rec_count_q <= rec_count_q + 1'b1;
    end
  end

  assign rec_count = rec_count_q;
`else
  assign rec_count = '0;
`endif

endmodule
